// File: rtl/id_ex_stage_reg_if.sv
// ID/EX stage bus: decoded ID-side fields in, registered EX-side fields out.
// The slave modport is the pipeline register itself.
// The master modport is whatever drives the ID fields and observes the EX outputs.
interface id_ex_stage_reg_if #(
  parameter int data_width    = 32,
  parameter int register_addr = 5,
  parameter int alu_op_width  = 4
);
  // Front-end control
  logic                     hold;
  logic                     flush;

  // ID-stage fields
  logic [register_addr-1:0] rs_id;
  logic [register_addr-1:0] rt_id;
  logic [register_addr-1:0] rd_id;
  logic                     rt_used_id;
  logic [data_width-1:0]    rs_data_id;
  logic [data_width-1:0]    rt_data_id;
  logic [data_width-1:0]    imm_id;
  logic                     reg_w_id;
  logic                     mem_r_id;
  logic                     mem_w_id;
  logic                     mem_to_reg_id;
  logic                     alu_src_id;
  logic                     reg_dst_id;
  logic [alu_op_width-1:0]  alu_op_id;

  // EX-stage (registered) fields
  logic [register_addr-1:0] rs_pip;
  logic [register_addr-1:0] rt_pip;
  logic [register_addr-1:0] wb_addr_pip;
  logic [data_width-1:0]    rs_data_pip;
  logic [data_width-1:0]    rt_data_pip;
  logic [data_width-1:0]    imm_pip;
  logic                     reg_w_pip;
  logic                     mem_r_pip;
  logic                     mem_w_pip;
  logic                     mem_to_reg_pip;
  logic                     alu_src_pip;
  logic [alu_op_width-1:0]  alu_op_pip;

  // Load-use stall back to PC and IF/ID
  logic                     stall;

  modport master (
    output hold, flush,
    output rs_id, rt_id, rd_id, rt_used_id, rs_data_id, rt_data_id, imm_id,
    output reg_w_id, mem_r_id, mem_w_id, mem_to_reg_id, alu_src_id, reg_dst_id, alu_op_id,
    input  rs_pip, rt_pip, wb_addr_pip, rs_data_pip, rt_data_pip, imm_pip,
    input  reg_w_pip, mem_r_pip, mem_w_pip, mem_to_reg_pip, alu_src_pip, alu_op_pip,
    input  stall
  );

  modport slave (
    input  hold, flush,
    input  rs_id, rt_id, rd_id, rt_used_id, rs_data_id, rt_data_id, imm_id,
    input  reg_w_id, mem_r_id, mem_w_id, mem_to_reg_id, alu_src_id, reg_dst_id, alu_op_id,
    output rs_pip, rt_pip, wb_addr_pip, rs_data_pip, rt_data_pip, imm_pip,
    output reg_w_pip, mem_r_pip, mem_w_pip, mem_to_reg_pip, alu_src_pip, alu_op_pip,
    output stall
  );
endinterface

// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register with load-use hazard detection.
// A load in EX whose destination is read by the instruction in ID causes
// a single bubble to be loaded while PC and IF/ID are stalled.
// Optional: define ID_EX_BUBBLE_CNT_EN to add a saturating 16-bit count of
// hazard bubbles on output bubble_cnt.
module id_ex_stage_reg #(
  parameter int data_width    = 32,
  parameter int register_addr = 5,
  parameter int alu_op_width  = 4
) (
  input  logic        clk,
  input  logic        rst,
`ifdef ID_EX_BUBBLE_CNT_EN
  output logic [15:0] bubble_cnt,
`endif
  id_ex_stage_reg_if.slave bus
);

  typedef struct packed {
    logic [register_addr-1:0] rs;
    logic [register_addr-1:0] rt;
    logic [register_addr-1:0] wb_addr;
    logic [data_width-1:0]    rs_data;
    logic [data_width-1:0]    rt_data;
    logic [data_width-1:0]    imm;
    logic                     reg_w;
    logic                     mem_r;
    logic                     mem_w;
    logic                     mem_to_reg;
    logic                     alu_src;
    logic [alu_op_width-1:0]  alu_op;
  } stage_t;

  stage_t stage_q;
  stage_t stage_d;
  logic   hz;
  logic   rs_dep;
  logic   rt_dep;

  // Load-use detection: the load in EX writes a register that ID reads ($0 excluded)
  always_comb begin
    rs_dep = (stage_q.wb_addr == bus.rs_id);
    rt_dep = bus.rt_used_id & (stage_q.wb_addr == bus.rt_id);
    hz     = stage_q.mem_r & stage_q.reg_w & (stage_q.wb_addr != '0) & (rs_dep | rt_dep);
  end

  // A flushed instruction is being killed, and hold freezes the front end anyway
  assign bus.stall = hz & ~bus.flush & ~bus.hold;

  // Next contents: keep on hold, bubble on flush or hazard, else capture ID fields
  always_comb begin
    stage_d = stage_q;
    if (!bus.hold) begin
      if (bus.flush || hz) begin
        stage_d = '0;
      end else begin
        stage_d.rs         = bus.rs_id;
        stage_d.rt         = bus.rt_id;
        stage_d.wb_addr    = bus.reg_dst_id ? bus.rd_id : bus.rt_id;
        stage_d.rs_data    = bus.rs_data_id;
        stage_d.rt_data    = bus.rt_data_id;
        stage_d.imm        = bus.imm_id;
        stage_d.reg_w      = bus.reg_w_id;
        stage_d.mem_r      = bus.mem_r_id;
        stage_d.mem_w      = bus.mem_w_id;
        stage_d.mem_to_reg = bus.mem_to_reg_id;
        stage_d.alu_src    = bus.alu_src_id;
        stage_d.alu_op     = bus.alu_op_id;
      end
    end
  end

  // Pipeline register, cleared to a bubble on reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stage_q <= '0;
    end else begin
      stage_q <= stage_d;
    end
  end

  assign bus.rs_pip         = stage_q.rs;
  assign bus.rt_pip         = stage_q.rt;
  assign bus.wb_addr_pip    = stage_q.wb_addr;
  assign bus.rs_data_pip    = stage_q.rs_data;
  assign bus.rt_data_pip    = stage_q.rt_data;
  assign bus.imm_pip        = stage_q.imm;
  assign bus.reg_w_pip      = stage_q.reg_w;
  assign bus.mem_r_pip      = stage_q.mem_r;
  assign bus.mem_w_pip      = stage_q.mem_w;
  assign bus.mem_to_reg_pip = stage_q.mem_to_reg;
  assign bus.alu_src_pip    = stage_q.alu_src;
  assign bus.alu_op_pip     = stage_q.alu_op;

`ifdef ID_EX_BUBBLE_CNT_EN
  logic [15:0] bubble_cnt_q;
  logic [15:0] bubble_cnt_d;

  // Count hazard bubbles only (not flush bubbles), saturating at all-ones
  always_comb begin
    bubble_cnt_d = bubble_cnt_q;
    if (bus.stall && (bubble_cnt_q != 16'hFFFF)) begin
      bubble_cnt_d = bubble_cnt_q + 16'd1;
    end
  end

  // Bubble counter register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bubble_cnt_q <= '0;
    end else begin
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign bubble_cnt = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Self-checking bench for id_ex_stage_reg: directed load-use, flush, hold and
// reset scenarios followed by randomized traffic against a reference model.
// Define ID_EX_BUBBLE_CNT_EN to also check the bubble counter.
module tb_id_ex_stage_reg;

  logic clk;
  logic rst;
`ifdef ID_EX_BUBBLE_CNT_EN
  logic [15:0] bubble_cnt;
`endif

  id_ex_stage_reg_if #(.data_width(32), .register_addr(5), .alu_op_width(4)) bus ();

  id_ex_stage_reg #(.data_width(32), .register_addr(5), .alu_op_width(4)) dut (
    .clk (clk),
    .rst (rst),
`ifdef ID_EX_BUBBLE_CNT_EN
    .bubble_cnt (bubble_cnt),
`endif
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int chk_cnt;
  int pass_cnt;

  // What the EX stage should currently hold: the instruction last accepted
  typedef struct {
    logic [4:0]  rs, rt, dest;
    logic [31:0] a, b, imm;
    logic        writes, loads, stores, from_mem, uses_imm;
    logic [3:0]  op;
  } ex_instr_t;

  ex_instr_t   ex;
  logic [15:0] exp_bubbles;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    chk_cnt++;
    if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
    else pass_cnt++;
  endtask

  function automatic logic [119:0] dut_vec();
    return {bus.rs_pip, bus.rt_pip, bus.wb_addr_pip, bus.rs_data_pip, bus.rt_data_pip,
            bus.imm_pip, bus.reg_w_pip, bus.mem_r_pip, bus.mem_w_pip, bus.mem_to_reg_pip,
            bus.alu_src_pip, bus.alu_op_pip};
  endfunction

  function automatic logic [119:0] model_vec();
    return {ex.rs, ex.rt, ex.dest, ex.a, ex.b, ex.imm, ex.writes, ex.loads, ex.stores,
            ex.from_mem, ex.uses_imm, ex.op};
  endfunction

  task automatic model_clear();
    ex = '{rs: 0, rt: 0, dest: 0, a: 0, b: 0, imm: 0, writes: 0, loads: 0,
           stores: 0, from_mem: 0, uses_imm: 0, op: 0};
  endtask

  // ID needs a value that a load currently in EX has not yet produced
  function automatic logic load_use();
    logic id_reads_dest;
    if (!(ex.loads && ex.writes)) return 1'b0;
    if (ex.dest == 5'd0) return 1'b0;
    id_reads_dest = (bus.rs_id == ex.dest) || (bus.rt_used_id && bus.rt_id == ex.dest);
    return id_reads_dest;
  endfunction

  function automatic logic exp_stall();
    return load_use() && !bus.flush && !bus.hold;
  endfunction

  // Apply one clock edge to the model using the inputs currently driven
  task automatic model_edge();
    if (bus.hold) return;
    if (bus.flush) begin
      model_clear();
    end else if (load_use()) begin
      if (exp_bubbles != 16'hFFFF) exp_bubbles++;
      model_clear();
    end else begin
      ex.rs       = bus.rs_id;
      ex.rt       = bus.rt_id;
      ex.dest     = bus.reg_dst_id ? bus.rd_id : bus.rt_id;
      ex.a        = bus.rs_data_id;
      ex.b        = bus.rt_data_id;
      ex.imm      = bus.imm_id;
      ex.writes   = bus.reg_w_id;
      ex.loads    = bus.mem_r_id;
      ex.stores   = bus.mem_w_id;
      ex.from_mem = bus.mem_to_reg_id;
      ex.uses_imm = bus.alu_src_id;
      ex.op       = bus.alu_op_id;
    end
  endtask

  task automatic drive_instr(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                             input logic rt_used, input logic reg_dst, input logic mem_r,
                             input logic reg_w);
    bus.rs_id         = rs;
    bus.rt_id         = rt;
    bus.rd_id         = rd;
    bus.rt_used_id    = rt_used;
    bus.reg_dst_id    = reg_dst;
    bus.mem_r_id      = mem_r;
    bus.reg_w_id      = reg_w;
    bus.mem_w_id      = 1'b0;
    bus.mem_to_reg_id = mem_r;
    bus.alu_src_id    = mem_r;
    bus.alu_op_id     = 4'($urandom);
    bus.rs_data_id    = $urandom;
    bus.rt_data_id    = $urandom;
    bus.imm_id        = $urandom;
  endtask

  // One cycle: check stall before the edge, then all registered outputs after it
  task automatic cycle();
    #1;
    check("stall", {127'd0, bus.stall}, {127'd0, exp_stall()});
    @(posedge clk);
    model_edge();
    #1;
    check("pipe", {8'd0, dut_vec()}, {8'd0, model_vec()});
`ifdef ID_EX_BUBBLE_CNT_EN
    check("bubble_cnt", {112'd0, bubble_cnt}, {112'd0, exp_bubbles});
`endif
  endtask

  initial begin
    chk_cnt  = 0;
    pass_cnt = 0;
    exp_bubbles = 16'd0;
    model_clear();
    bus.hold  = 1'b0;
    bus.flush = 1'b0;
    drive_instr(5'($urandom), 5'($urandom), 5'($urandom), 1'b1, 1'b1, 1'b1, 1'b1);

    // Reset with random inputs: outputs clear before any clock edge
    rst = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("rst_pipe", {8'd0, dut_vec()}, 128'd0);
    check("rst_stall", {127'd0, bus.stall}, 128'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Pass-through
    drive_instr(5'd3, 5'd4, 5'd5, 1'b1, 1'b1, 1'b0, 1'b1);
    bus.alu_op_id  = 4'h2;
    bus.rs_data_id = 32'h11;
    cycle();
    check("pt_rs", {123'd0, bus.rs_pip}, 128'd3);
    check("pt_rt", {123'd0, bus.rt_pip}, 128'd4);
    check("pt_wb", {123'd0, bus.wb_addr_pip}, 128'd5);
    check("pt_regw", {127'd0, bus.reg_w_pip}, 128'd1);
    check("pt_aluop", {124'd0, bus.alu_op_pip}, 128'd2);
    check("pt_rsdata", {96'd0, bus.rs_data_pip}, 128'h11);

    // Load-use: lw into $8, then a reader of $8
    drive_instr(5'd1, 5'd8, 5'd2, 1'b0, 1'b0, 1'b1, 1'b1);
    cycle();
    drive_instr(5'd8, 5'd3, 5'd4, 1'b1, 1'b1, 1'b0, 1'b1);
    #1 check("lu_stall", {127'd0, bus.stall}, 128'd1);
    cycle();
    check("lu_bub_regw", {127'd0, bus.reg_w_pip}, 128'd0);
    check("lu_bub_memr", {127'd0, bus.mem_r_pip}, 128'd0);
    check("lu_stall_gone", {127'd0, bus.stall}, 128'd0);
    cycle();
    check("lu_dep_rs", {123'd0, bus.rs_pip}, 128'd8);

    // Load to $0 never stalls
    drive_instr(5'd1, 5'd0, 5'd2, 1'b0, 1'b0, 1'b1, 1'b1);
    cycle();
    drive_instr(5'd0, 5'd0, 5'd4, 1'b1, 1'b1, 1'b0, 1'b1);
    #1 check("zero_stall", {127'd0, bus.stall}, 128'd0);
    cycle();

    // rt matches but is not read
    drive_instr(5'd1, 5'd9, 5'd2, 1'b0, 1'b0, 1'b1, 1'b1);
    cycle();
    drive_instr(5'd1, 5'd9, 5'd4, 1'b0, 1'b1, 1'b0, 1'b1);
    #1 check("rtunused_stall", {127'd0, bus.stall}, 128'd0);
    cycle();

    // Flush beats hazard, bubble not counted
    drive_instr(5'd1, 5'd7, 5'd2, 1'b0, 1'b0, 1'b1, 1'b1);
    cycle();
    drive_instr(5'd7, 5'd3, 5'd4, 1'b1, 1'b1, 1'b0, 1'b1);
    bus.flush = 1'b1;
    #1 check("flush_stall", {127'd0, bus.stall}, 128'd0);
    cycle();
    check("flush_regw", {127'd0, bus.reg_w_pip}, 128'd0);
    check("flush_rs", {123'd0, bus.rs_pip}, 128'd0);
`ifdef ID_EX_BUBBLE_CNT_EN
    check("flush_cnt", {112'd0, bubble_cnt}, 128'd1);
`endif
    bus.flush = 1'b0;

    // Hold during a pending hazard, then exactly one stall cycle
    drive_instr(5'd1, 5'd6, 5'd2, 1'b0, 1'b0, 1'b1, 1'b1);
    cycle();
    drive_instr(5'd6, 5'd3, 5'd4, 1'b1, 1'b1, 1'b0, 1'b1);
    bus.hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1 check("hold_stall", {127'd0, bus.stall}, 128'd0);
      cycle();
      check("hold_wb", {123'd0, bus.wb_addr_pip}, 128'd6);
      check("hold_memr", {127'd0, bus.mem_r_pip}, 128'd1);
    end
    bus.hold = 1'b0;
    #1 check("rel_stall", {127'd0, bus.stall}, 128'd1);
    cycle();
    check("rel_stall_once", {127'd0, bus.stall}, 128'd0);
`ifdef ID_EX_BUBBLE_CNT_EN
    check("rel_cnt", {112'd0, bubble_cnt}, 128'd2);
`endif
    cycle();
    check("rel_dep_rs", {123'd0, bus.rs_pip}, 128'd6);

    // Reset mid-stall drops everything immediately
    drive_instr(5'd1, 5'd5, 5'd2, 1'b0, 1'b0, 1'b1, 1'b1);
    cycle();
    drive_instr(5'd5, 5'd3, 5'd4, 1'b1, 1'b1, 1'b0, 1'b1);
    #1 check("pre_rst_stall", {127'd0, bus.stall}, 128'd1);
    rst = 1'b1;
    #1;
    check("midrst_stall", {127'd0, bus.stall}, 128'd0);
    check("midrst_pipe", {8'd0, dut_vec()}, 128'd0);
`ifdef ID_EX_BUBBLE_CNT_EN
    check("midrst_cnt", {112'd0, bubble_cnt}, 128'd0);
`endif
    model_clear();
    exp_bubbles = 16'd0;
    #1 rst = 1'b0;

    // Randomized traffic with small register indices to provoke hazards
    for (int n = 0; n < 1500; n++) begin
      drive_instr(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                  1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
      bus.mem_w_id      = 1'($urandom);
      bus.mem_to_reg_id = 1'($urandom);
      bus.alu_src_id    = 1'($urandom);
      bus.hold  = ($urandom_range(0, 7) == 0);
      bus.flush = ($urandom_range(0, 7) == 0);
      cycle();
    end

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/id_ex_stage_reg.md
Name: id_ex_stage_reg

Overview:
- ID/EX pipeline register with integrated load-use hazard detection.
- Captures decoded instruction fields, register-file read data and control bits from the ID stage.
- Drives the EX stage: rs_pip/rt_pip go to the forwarding unit; wb_addr_pip goes to the EX/MEM register.
- Inserts a one-cycle bubble on a load-use dependency and stalls PC and IF/ID.

Parameters:
data_width, 32, operand/immediate width
register_addr, 5, register index width
alu_op_width, 4, ALU opcode width

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  asynchronous active-high reset
hold  input  1  global freeze (memory wait); register keeps contents
flush  input  1  branch-taken kill from EX; load bubble
rs_id  input  register_addr  source register index, ID stage
rt_id  input  register_addr  second source / load destination index
rd_id  input  register_addr  R-type destination index
rt_used_id  input  1  instruction in ID reads rt
rs_data_id  input  data_width  register-file read data A
rt_data_id  input  data_width  register-file read data B
imm_id  input  data_width  sign-extended immediate
reg_w_id, mem_r_id, mem_w_id, mem_to_reg_id, alu_src_id, reg_dst_id  input  1 each  decoded control bits
alu_op_id  input  alu_op_width  ALU operation
rs_pip, rt_pip  output  register_addr  registered sources to forwarding unit
wb_addr_pip  output  register_addr  registered destination: rd_id if reg_dst_id else rt_id
rs_data_pip, rt_data_pip, imm_pip  output  data_width  registered data
reg_w_pip, mem_r_pip, mem_w_pip, mem_to_reg_pip, alu_src_pip  output  1 each  registered control
alu_op_pip  output  alu_op_width  registered ALU op
stall  output  1  combinational; hold PC and IF/ID when high

Behaviour:
- Reset (async, rst=1): every registered output = 0. stall = 0 while the register holds a bubble.
- Hazard (combinational): hz = mem_r_pip & reg_w_pip & (wb_addr_pip != 0) & ((wb_addr_pip == rs_id) | (rt_used_id & (wb_addr_pip == rt_id))).
- Stall: stall = hz & ~flush & ~hold.
- Update priority per rising edge, highest first:
  1. hold=1: all registers keep their value. stall=0; the external hold already freezes the front end.
  2. flush=1: load bubble. All control outputs = 0; indices and data = 0.
  3. hz=1: load bubble. stall=1 this cycle.
  4. Otherwise load ID fields. wb_addr_pip is selected by reg_dst_id before registering.
- Latency: exactly 1 cycle ID→EX. A stalled instruction enters the register one cycle later.
- A bubble clears mem_r_pip, so hz never holds for more than one consecutive cycle. A load-use sequence therefore produces exactly one bubble.
- Register $0 never causes a hazard.
- flush and hz in the same cycle: flush wins and stall=0, since the dependent instruction is being killed.
- hold deasserting mid-hazard: hz is re-evaluated against unchanged contents and resumes normally.
- Reset mid-stall: outputs clear asynchronously and stall drops immediately.

Optional Feature:
- Macro ID_EX_BUBBLE_CNT_EN.
- Defined:
  - Adds output bubble_cnt [15:0], reset to 0.
  - Increments on each edge where a hazard bubble is loaded: hz & ~flush & ~hold.
  - Flush bubbles are not counted.
  - Saturates at 16'hFFFF.
- Undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset: assert rst with random inputs → all outputs 0 and stall=0 asynchronously, before any clock edge.
- Pass-through: rs_id=3, rt_id=4, rd_id=5, reg_dst_id=1, reg_w_id=1, alu_op_id=4'h2, rs_data_id=32'h11 → next cycle rs_pip=3, rt_pip=4, wb_addr_pip=5, reg_w_pip=1, alu_op_pip=2, rs_data_pip=32'h11.
- Load-use: load with rt_id=8, reg_dst_id=0, mem_r_id=1, reg_w_id=1, followed by rs_id=8 →
  - next cycle stall=1;
  - following edge loads a bubble (reg_w_pip=0, mem_r_pip=0) and stall=0;
  - edge after that loads the dependent instruction.
- $0 and rt_used: load targets $0 → no stall. Load targets $9 while ID has rt_id=9, rt_used_id=0 → no stall.
- Flush vs stall: load-use hazard present and flush=1 → stall=0 and a bubble is loaded. With ID_EX_BUBBLE_CNT_EN defined, bubble_cnt is unchanged.
- Hold: hold=1 for 3 cycles during a pending hazard → outputs frozen and stall=0. After release, stall=1 for exactly one cycle. With the macro defined, bubble_cnt increments by 1; preloaded at 16'hFFFF, it stays at 16'hFFFF.
